// File: rtl/tqvp_gera_gray_pkg.sv
// Shared definitions for the Gray-code engine peripheral: register map,
// CTRL/STATUS bit positions, conversion FSM states and a byte-select helper.
package tqvp_gera_gray_pkg;

  // Register map (4-bit address space)
  localparam logic [3:0] ADDR_CTRL   = 4'h0;
  localparam logic [3:0] ADDR_OP0    = 4'h1;
  localparam logic [3:0] ADDR_OP3    = 4'h4;
  localparam logic [3:0] ADDR_RES0   = 4'h5;
  localparam logic [3:0] ADDR_RES3   = 4'h8;
  localparam logic [3:0] ADDR_STATUS = 4'h9;
  localparam logic [3:0] ADDR_PRE_LO = 4'hA;
  localparam logic [3:0] ADDR_PRE_HI = 4'hB;
  localparam logic [3:0] ADDR_CNT0   = 4'hC;

  // CTRL bit positions
  localparam int CTRL_MODE     = 0;
  localparam int CTRL_CNT_EN   = 1;
  localparam int CTRL_CNT_DIR  = 2;
  localparam int CTRL_UO_SEL   = 3;
  localparam int CTRL_SOFT_CLR = 7;

  // STATUS bit positions
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_OVERRUN = 2;

  // Conversion engine states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } gray_state_e;

  // Pick byte idx out of a 32-bit word; narrower values are zero-extended by
  // the caller so bytes beyond the operand width naturally read as zero.
  function automatic logic [7:0] selByte(input logic [31:0] word, input logic [1:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/tqvp_gera_gray_serial.sv
// Bit-serial Gray converter: one result bit per clock, MSB first.
// bin->gray: r[i] = b[i] ^ b[i+1]; gray->bin: r[i] = g[i] ^ r[i+1].
// The result register only changes on the final bit, so readers never see
// a partially assembled value. Abort returns to idle and zeroes the result.
module tqvp_gera_gray_serial #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_mode,
  input  logic [WIDTH-1:0] i_op,
  input  logic             i_abort,
  output logic             o_busy,
  output logic             o_done_pulse,
  output logic [WIDTH-1:0] o_result
);
  import tqvp_gera_gray_pkg::*;

  localparam int IW = $clog2(WIDTH);

  gray_state_e      r_state;
  gray_state_e      w_stateNext;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-2:0] r_acc;
  logic [WIDTH-1:0] r_result;
  logic [IW-1:0]    r_idx;
  logic             r_mode;
  logic             r_prevIn;
  logic             r_prevOut;
  logic             w_bit;
  logic             w_lastBit;

  // r_prevIn holds the operand bit above the current one, r_prevOut the result
  // bit above; both start at 0 so the MSB passes straight through.
  assign w_bit        = r_mode ? (r_shift[WIDTH-1] ^ r_prevOut) : (r_shift[WIDTH-1] ^ r_prevIn);
  assign w_lastBit    = (r_state == ST_CONV) && (r_idx == '0);
  assign o_busy       = (r_state == ST_CONV);
  assign o_done_pulse = w_lastBit && !i_abort;
  assign o_result     = r_result;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state: launch from idle, leave CONV after the last bit or on abort
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE: if (i_start && !i_abort) w_stateNext = ST_CONV;
      ST_CONV: if (i_abort || w_lastBit) w_stateNext = ST_IDLE;
      default: w_stateNext = ST_IDLE;
    endcase
  end

  // Datapath: latch operand/mode on launch, then shift one bit per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_acc     <= '0;
      r_result  <= '0;
      r_idx     <= '0;
      r_mode    <= 1'b0;
      r_prevIn  <= 1'b0;
      r_prevOut <= 1'b0;
    end else if (i_abort) begin
      r_result <= '0;
      r_idx    <= '0;
    end else if (r_state == ST_IDLE) begin
      if (i_start) begin
        r_shift   <= i_op;
        r_mode    <= i_mode;
        r_idx     <= IW'(WIDTH - 1);
        r_prevIn  <= 1'b0;
        r_prevOut <= 1'b0;
      end
    end else begin
      r_shift   <= {r_shift[WIDTH-2:0], 1'b0};
      r_prevIn  <= r_shift[WIDTH-1];
      r_prevOut <= w_bit;
      r_acc     <= {r_acc[WIDTH-3:0], w_bit};
      r_idx     <= r_idx - IW'(1);
      if (w_lastBit) begin
        r_result <= {r_acc, w_bit};
      end
    end
  end

endmodule

// File: rtl/tqvp_gera_gray_engine.sv
// TinyQV peripheral: register file around the bit-serial Gray converter, plus
// a prescaled up/down Gray-code counter. Either result can drive uo_out.
// WIDTH must be a multiple of 8 in 8..32; PRESCALE_W must be at most 32.
module tqvp_gera_gray_engine #(
  parameter int WIDTH      = 16,
  parameter int PRESCALE_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);
  import tqvp_gera_gray_pkg::*;

  localparam int NBYTES = WIDTH / 8;

  logic [3:0]            r_ctrl;
  logic [WIDTH-1:0]      r_operand;
  logic                  r_done;
  logic                  r_overrun;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [PRESCALE_W-1:0] r_preCnt;
  logic [WIDTH-1:0]      r_cntBin;

  logic                  w_wrCtrl;
  logic                  w_softClear;
  logic                  w_isOp;
  logic [1:0]            w_opIdx;
  logic                  w_launch;
  logic [WIDTH-1:0]      w_opLaunch;
  logic                  w_cntZero;
  logic                  w_busy;
  logic                  w_donePulse;
  logic [WIDTH-1:0]      w_result;
  logic [WIDTH-1:0]      w_cntGray;
  logic [31:0]           w_result32;
  logic [31:0]           w_cntGray32;
  logic [31:0]           w_prescale32;
  logic                  _unused;

  assign _unused = &{1'b0, ui_in};

  assign w_wrCtrl    = data_write && (address == ADDR_CTRL);
  assign w_softClear = w_wrCtrl && data_in[CTRL_SOFT_CLR];
  assign w_isOp      = data_write && (address >= ADDR_OP0) && (address <= ADDR_OP3);
  assign w_opIdx     = 2'(address - ADDR_OP0);
  assign w_launch    = w_isOp && !w_busy && (int'(w_opIdx) == NBYTES - 1);
  assign w_cntZero   = data_write && (address == ADDR_CNT0);

  assign w_cntGray    = r_cntBin ^ (r_cntBin >> 1);
  assign w_result32   = 32'(w_result);
  assign w_cntGray32  = 32'(w_cntGray);
  assign w_prescale32 = 32'(r_prescale);

  assign uo_out = r_ctrl[CTRL_UO_SEL] ? w_cntGray[7:0] : w_result[7:0];

  // The launching MSB byte comes straight off the bus; lower bytes from the register
  always_comb begin
    w_opLaunch = r_operand;
    w_opLaunch[WIDTH-1 -: 8] = data_in;
  end

  tqvp_gera_gray_serial #(
    .WIDTH(WIDTH)
  ) u_serial (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (w_launch),
    .i_mode       (r_ctrl[CTRL_MODE]),
    .i_op         (w_opLaunch),
    .i_abort      (w_softClear),
    .o_busy       (w_busy),
    .o_done_pulse (w_donePulse),
    .o_result     (w_result)
  );

  // CTRL: a soft_clear write leaves the stored control bits untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl <= '0;
    end else if (w_wrCtrl && !data_in[CTRL_SOFT_CLR]) begin
      r_ctrl <= data_in[3:0];
    end
  end

  // OPERAND bytes: accepted only while idle; bytes beyond WIDTH are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_operand <= '0;
    end else if (w_isOp && !w_busy) begin
      for (int k = 0; k < NBYTES; k++) begin
        if (int'(w_opIdx) == k) begin
          r_operand[8*k +: 8] <= data_in;
        end
      end
    end
  end

  // STATUS sticky bits: a done pulse outranks a same-cycle clear so it is never lost
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_softClear) begin
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (data_write && (address == ADDR_STATUS)) begin
        r_done    <= 1'b0;
        r_overrun <= 1'b0;
      end
      if (w_donePulse) begin
        r_done <= 1'b1;
      end
      if (w_isOp && w_busy) begin
        r_overrun <= 1'b1;
      end
    end
  end

  // PRESCALE lo/hi bytes; bits beyond PRESCALE_W do not exist
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prescale <= '0;
    end else if (data_write) begin
      for (int b = 0; b < PRESCALE_W; b++) begin
        if ((address == ADDR_PRE_LO) && (b < 8)) begin
          r_prescale[b] <= data_in[b % 8];
        end
        if ((address == ADDR_PRE_HI) && (b >= 8) && (b < 16)) begin
          r_prescale[b] <= data_in[b % 8];
        end
      end
    end
  end

  // Prescaler and counter: >= compare so a lowered PRESCALE applies at once,
  // and a zeroing write wins over a step in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_preCnt <= '0;
      r_cntBin <= '0;
    end else if (w_softClear || w_cntZero) begin
      r_preCnt <= '0;
      r_cntBin <= '0;
    end else if (r_ctrl[CTRL_CNT_EN]) begin
      if (r_preCnt >= r_prescale) begin
        r_preCnt <= '0;
        r_cntBin <= r_ctrl[CTRL_CNT_DIR] ? (r_cntBin - WIDTH'(1)) : (r_cntBin + WIDTH'(1));
      end else begin
        r_preCnt <= r_preCnt + PRESCALE_W'(1);
      end
    end
  end

  // Read mux: combinational from address, unmapped or write-only bytes read 0
  always_comb begin
    data_out = '0;
    case (address)
      ADDR_CTRL:   data_out = {4'b0000, r_ctrl};
      ADDR_STATUS: data_out = {5'b00000, r_overrun, r_done, w_busy};
      ADDR_PRE_LO: data_out = selByte(w_prescale32, 2'd0);
      ADDR_PRE_HI: data_out = selByte(w_prescale32, 2'd1);
      default: begin
        if ((address >= ADDR_RES0) && (address <= ADDR_RES3)) begin
          data_out = selByte(w_result32, 2'(address - ADDR_RES0));
        end else if (address >= ADDR_CNT0) begin
          data_out = selByte(w_cntGray32, 2'(address - ADDR_CNT0));
        end
      end
    endcase
  end

endmodule

// File: tb/tb_tqvp_gera_gray_engine.sv
// Directed bench for the Gray engine peripheral (WIDTH=16). Expected results
// are pushed to a queue when a launch or counter run is driven, then popped
// and compared when the DUT produces them.
module tb_tqvp_gera_gray_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uo_out;
  logic [3:0] address = 4'h0;
  logic       data_write = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [15:0] value;
  } expect_t;

  expect_t scoreQ[$];

  // 100 MHz bench clock
  always #5 clk = ~clk;

  tqvp_gera_gray_engine #(
    .WIDTH(16),
    .PRESCALE_W(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ui_in      (ui_in),
    .uo_out     (uo_out),
    .address    (address),
    .data_write (data_write),
    .data_in    (data_in),
    .data_out   (data_out)
  );

  // Reference conversions written directly from the word-level definitions
  function automatic logic [15:0] binToGray(input logic [15:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [15:0] grayToBin(input logic [15:0] g);
    logic [15:0] r;
    r[15] = g[15];
    for (int i = 14; i >= 0; i--) r[i] = g[i] ^ r[i+1];
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One-cycle register write; returns on the negedge after the write edge
  task automatic applyStimulus(input logic [3:0] addr, input logic [7:0] data);
    @(negedge clk);
    address    = addr;
    data_in    = data;
    data_write = 1'b1;
    @(negedge clk);
    data_write = 1'b0;
  endtask

  task automatic readReg(input logic [3:0] addr, output logic [7:0] value);
    address = addr;
    #1;
    value = data_out;
  endtask

  task automatic read16(input logic [3:0] base, output logic [15:0] value);
    logic [7:0] lo;
    logic [7:0] hi;
    readReg(base, lo);
    readReg(base + 4'h1, hi);
    value = {hi, lo};
  endtask

  task automatic checkByte(input string tag, input logic [3:0] addr, input logic [7:0] expected);
    logic [7:0] v;
    readReg(addr, v);
    checkOutput(tag, {8'h00, v}, {8'h00, expected});
  endtask

  task automatic pushExpect(input string tag, input logic [15:0] value);
    expect_t e;
    e.tag   = tag;
    e.value = value;
    scoreQ.push_back(e);
  endtask

  task automatic popAndCheck(input logic [15:0] observed);
    expect_t e;
    if (scoreQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_empty: observed 0x%0h with no expected entry", observed);
    end else begin
      e = scoreQ.pop_front();
      checkOutput(e.tag, observed, e.value);
    end
  endtask

  // Counts cycles with busy high, bounded; a stuck busy is a failed check
  task automatic measureBusy(input string tag, output int n);
    logic [7:0] s;
    n = 0;
    readReg(4'h9, s);
    while (s[0] && n < 200) begin
      n++;
      @(negedge clk);
      readReg(4'h9, s);
    end
    checkOutput({tag, "_idle"}, {15'h0, s[0]}, 16'h0000);
  endtask

  // Global time limit so the bench can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] v16;
    logic [15:0] op;
    logic [15:0] prev;
    logic [15:0] expG;
    logic [15:0] cntSeq [4];
    int          n;

    // Reset state
    #1;
    checkOutput("reset_uo_out", {8'h00, uo_out}, 16'h0000);
    checkByte("reset_ctrl", 4'h0, 8'h00);
    checkByte("reset_status", 4'h9, 8'h00);
    checkByte("reset_result0", 4'h5, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // bin->gray of 0x1234, full latency check
    applyStimulus(4'h0, 8'h00);
    applyStimulus(4'h1, 8'h34);
    pushExpect("conv_b2g_1234", binToGray(16'h1234));
    applyStimulus(4'h2, 8'h12);
    checkByte("result_hold_during_conv", 4'h5, 8'h00);
    measureBusy("conv1", n);
    checkOutput("busy_cycles", 16'(n), 16'd16);
    read16(4'h5, v16);
    popAndCheck(v16);
    checkByte("status_done", 4'h9, 8'h02);
    checkOutput("uo_out_result", {8'h00, uo_out}, {8'h00, binToGray(16'h1234) & 16'h00FF});
    prev = binToGray(16'h1234);

    // gray->bin of 0x8000 with an overrun write mid-conversion
    applyStimulus(4'h9, 8'h00);
    checkByte("status_cleared", 4'h9, 8'h00);
    applyStimulus(4'h0, 8'h01);
    applyStimulus(4'h1, 8'h00);
    pushExpect("conv_g2b_8000", grayToBin(16'h8000));
    applyStimulus(4'h2, 8'h80);
    repeat (3) @(negedge clk);
    applyStimulus(4'h1, 8'hAA);
    checkByte("status_busy_overrun", 4'h9, 8'h05);
    read16(4'h5, v16);
    checkOutput("result_unchanged_overrun", v16, prev);
    measureBusy("conv2", n);
    read16(4'h5, v16);
    popAndCheck(v16);
    checkByte("status_done_overrun", 4'h9, 8'h06);

    // Dropped byte must not reach the operand; mode change mid-run is ignored
    applyStimulus(4'h9, 8'h00);
    applyStimulus(4'h0, 8'h00);
    pushExpect("conv_drop_mode", binToGray(16'h5A00));
    applyStimulus(4'h2, 8'h5A);
    repeat (2) @(negedge clk);
    applyStimulus(4'h0, 8'h01);
    measureBusy("conv3", n);
    read16(4'h5, v16);
    popAndCheck(v16);
    checkByte("status_done_only", 4'h9, 8'h02);

    // Unmapped and write-only bytes read zero
    checkByte("read_op_wo", 4'h3, 8'h00);
    checkByte("read_result_byte2", 4'h7, 8'h00);
    checkByte("read_result_byte3", 4'h8, 8'h00);
    checkByte("read_cnt_byte2", 4'hE, 8'h00);
    checkByte("read_cnt_byte3", 4'hF, 8'h00);

    // A few random operands in both modes
    for (int i = 0; i < 4; i++) begin
      op = 16'($urandom);
      applyStimulus(4'h0, {7'b0, 1'(i % 2)});
      applyStimulus(4'h1, op[7:0]);
      pushExpect((i % 2) ? "conv_rand_g2b" : "conv_rand_b2g", (i % 2) ? grayToBin(op) : binToGray(op));
      applyStimulus(4'h2, op[15:8]);
      measureBusy("conv_rand", n);
      read16(4'h5, v16);
      popAndCheck(v16);
    end

    // Counter up, PRESCALE=3: steps every 4 cycles, uo_out follows it
    applyStimulus(4'h0, 8'h00);
    applyStimulus(4'hA, 8'h03);
    applyStimulus(4'hB, 8'h00);
    applyStimulus(4'hC, 8'h00);
    for (int s = 0; s < 4; s++) begin
      cntSeq[s] = binToGray(16'(s));
      pushExpect("cnt_up_step", cntSeq[s]);
    end
    applyStimulus(4'h0, 8'h0A);
    read16(4'hC, v16);
    popAndCheck(v16);
    for (int s = 1; s < 4; s++) begin
      repeat (3) @(negedge clk);
      read16(4'hC, v16);
      checkOutput("cnt_hold_before_step", v16, cntSeq[s-1]);
      @(negedge clk);
      read16(4'hC, v16);
      popAndCheck(v16);
      checkOutput("uo_out_counter", {8'h00, uo_out}, {8'h00, cntSeq[s][7:0]});
    end
    checkByte("prescale_lo_read", 4'hA, 8'h03);

    // Counter down from zero, PRESCALE=0: wraps to all-ones
    applyStimulus(4'h0, 8'h00);
    applyStimulus(4'hC, 8'h00);
    applyStimulus(4'hA, 8'h00);
    expG = binToGray(16'hFFFF);
    applyStimulus(4'h0, 8'h06);
    read16(4'hC, v16);
    checkOutput("cnt_down_start", v16, 16'h0000);
    @(negedge clk);
    read16(4'hC, v16);
    checkOutput("cnt_down_wrap", v16, expG);
    applyStimulus(4'hC, 8'h00);
    read16(4'hC, v16);
    checkOutput("cnt_zero_wins", v16, 16'h0000);
    @(negedge clk);
    read16(4'hC, v16);
    checkOutput("cnt_after_zero", v16, expG);

    // soft_clear part-way through a conversion
    applyStimulus(4'h0, 8'h00);
    applyStimulus(4'h9, 8'h00);
    applyStimulus(4'hA, 8'h05);
    applyStimulus(4'h0, 8'h02);
    repeat (12) @(negedge clk);
    applyStimulus(4'h1, 8'h11);
    pushExpect("softclr_result", 16'h0000);
    applyStimulus(4'h2, 8'h22);
    repeat (4) @(negedge clk);
    applyStimulus(4'h0, 8'h82);
    checkByte("softclr_status", 4'h9, 8'h00);
    read16(4'h5, v16);
    popAndCheck(v16);
    read16(4'hC, v16);
    checkOutput("softclr_counter", v16, 16'h0000);
    checkByte("softclr_prescale", 4'hA, 8'h05);
    checkByte("softclr_ctrl", 4'h0, 8'h02);

    // Asynchronous reset mid-conversion with the counter on uo_out
    applyStimulus(4'hA, 8'h00);
    applyStimulus(4'h0, 8'h0A);
    applyStimulus(4'h1, 8'h77);
    applyStimulus(4'h2, 8'h66);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_uo_out", {8'h00, uo_out}, 16'h0000);
    checkByte("async_reset_status", 4'h9, 8'h00);
    @(negedge clk);
    checkByte("async_reset_ctrl", 4'h0, 8'h00);
    rst_n = 1'b1;

    // Fresh launch after reset release
    applyStimulus(4'h1, 8'hCD);
    pushExpect("conv_after_reset", binToGray(16'hABCD));
    applyStimulus(4'h2, 8'hAB);
    measureBusy("conv_post_reset", n);
    checkOutput("busy_cycles_post_reset", 16'(n), 16'd16);
    read16(4'h5, v16);
    popAndCheck(v16);
    checkOutput("uo_out_post_reset", {8'h00, uo_out}, {8'h00, binToGray(16'hABCD) & 16'h00FF});

    if (scoreQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_leftover: %0d entries remain, required 0", scoreQ.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
